// File: rtl/adat_frame_deserializer.sv
// ADAT frame deserializer: locks onto the zero-run sync pattern, strips the 1-bit
// nibble separators and delivers user bits plus per-channel samples with lock status.
`timescale 1ns/1ps
module adat_frame_deserializer #(
  parameter int CHANNELS     = 8,
  parameter int SAMPLE_WIDTH = 24,
  parameter int SYNC_ZEROS   = 10,
  parameter int LOCK_FRAMES  = 2,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in,
  input  logic                    enable,
  output logic [SAMPLE_WIDTH-1:0] sample_data,
  output logic [CH_W-1:0]         sample_channel,
  output logic                    sample_rdy,
  output logic [3:0]              user_bits,
  output logic                    frame_rdy,
  output logic                    locked,
  output logic                    error
);

  localparam int              NIBS     = SAMPLE_WIDTH / 4;
  localparam logic [3:0]      SYNC_LEN = 4'(SYNC_ZEROS);
  localparam logic [3:0]      LOCK_LEN = 4'(LOCK_FRAMES);
  localparam logic [2:0]      LAST_NIB = 3'(NIBS - 1);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(CHANNELS - 1);

  typedef enum logic [1:0] {HUNT, USER, DATA, SYNC} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              zero_cnt, zero_nxt;
  logic [2:0]              bit_cnt, bit_nxt;
  logic [2:0]              nib_cnt, nib_nxt;
  logic [CH_W-1:0]         chan_cnt, chan_nxt;
  logic [3:0]              good_cnt, good_nxt;
  logic [3:0]              user_sr, user_sr_nxt;
  logic [SAMPLE_WIDTH-1:0] sample_sr, sample_sr_nxt;
  logic [SAMPLE_WIDTH-1:0] sample_data_nxt;
  logic [CH_W-1:0]         sample_channel_nxt;
  logic [3:0]              user_bits_nxt;
  logic                    sample_rdy_nxt, frame_rdy_nxt, locked_nxt, error_nxt;
  logic                    fault;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // NOTE: every signal gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_nxt          = state;
    zero_nxt           = zero_cnt;
    bit_nxt            = bit_cnt;
    nib_nxt            = nib_cnt;
    chan_nxt           = chan_cnt;
    good_nxt           = good_cnt;
    user_sr_nxt        = user_sr;
    sample_sr_nxt      = sample_sr;
    sample_data_nxt    = sample_data;
    sample_channel_nxt = sample_channel;
    user_bits_nxt      = user_bits;
    locked_nxt         = locked;
    sample_rdy_nxt     = 1'b0;
    frame_rdy_nxt      = 1'b0;
    error_nxt          = 1'b0;
    fault              = 1'b0;

    if (enable) begin
      unique case (state)
        HUNT: begin
          if (!in) begin
            zero_nxt = sat_inc(zero_cnt);
          end else begin
            zero_nxt = 4'd0;
            if (zero_cnt >= SYNC_LEN) begin
              state_nxt = USER;
              bit_nxt   = 3'd0;
            end
          end
        end
        USER: begin
          if (bit_cnt != 3'd4) begin
            user_sr_nxt = {user_sr[2:0], in};
            bit_nxt     = bit_cnt + 3'd1;
          end else if (in) begin
            user_bits_nxt = user_sr;
            state_nxt     = DATA;
            bit_nxt       = 3'd0;
            nib_nxt       = 3'd0;
            chan_nxt      = '0;
          end else begin
            fault = 1'b1;
          end
        end
        DATA: begin
          if (bit_cnt != 3'd4) begin
            sample_sr_nxt = {sample_sr[SAMPLE_WIDTH-2:0], in};
            bit_nxt       = bit_cnt + 3'd1;
          end else if (!in) begin
            fault = 1'b1;
          end else begin
            bit_nxt = 3'd0;
            if (nib_cnt != LAST_NIB) begin
              nib_nxt = nib_cnt + 3'd1;
            end else begin
              nib_nxt            = 3'd0;
              sample_data_nxt    = sample_sr;
              sample_channel_nxt = chan_cnt;
              sample_rdy_nxt     = 1'b1;
              if (chan_cnt != LAST_CH) begin
                chan_nxt = chan_cnt + CH_W'(1);
              end else begin
                chan_nxt      = '0;
                frame_rdy_nxt = 1'b1;
                state_nxt     = SYNC;
                zero_nxt      = 4'd0;
                good_nxt      = (good_cnt == LOCK_LEN) ? LOCK_LEN : good_cnt + 4'd1;
                locked_nxt    = (good_nxt == LOCK_LEN);
              end
            end
          end
        end
        SYNC: begin
          if (!in) begin
            if (zero_cnt == SYNC_LEN) fault = 1'b1;
            else                      zero_nxt = zero_cnt + 4'd1;
          end else if (zero_cnt == SYNC_LEN) begin
            state_nxt = USER;
            zero_nxt  = 4'd0;
            bit_nxt   = 3'd0;
          end else begin
            fault = 1'b1;
          end
        end
        default: state_nxt = HUNT;
      endcase

      // The offending bit seeds the hunt's zero run, so an over-long sync can still be caught.
      if (fault) begin
        state_nxt  = HUNT;
        error_nxt  = 1'b1;
        locked_nxt = 1'b0;
        good_nxt   = 4'd0;
        bit_nxt    = 3'd0;
        nib_nxt    = 3'd0;
        chan_nxt   = '0;
        zero_nxt   = in ? 4'd0 : sat_inc(zero_cnt);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= HUNT;
      zero_cnt       <= 4'd0;
      bit_cnt        <= 3'd0;
      nib_cnt        <= 3'd0;
      chan_cnt       <= '0;
      good_cnt       <= 4'd0;
      // NOTE: the shift registers are small, so they are cleared too for a deterministic reset state.
      user_sr        <= 4'd0;
      sample_sr      <= '0;
      sample_data    <= '0;
      sample_channel <= '0;
      user_bits      <= 4'd0;
      sample_rdy     <= 1'b0;
      frame_rdy      <= 1'b0;
      locked         <= 1'b0;
      error          <= 1'b0;
    end else begin
      state          <= state_nxt;
      zero_cnt       <= zero_nxt;
      bit_cnt        <= bit_nxt;
      nib_cnt        <= nib_nxt;
      chan_cnt       <= chan_nxt;
      good_cnt       <= good_nxt;
      user_sr        <= user_sr_nxt;
      sample_sr      <= sample_sr_nxt;
      sample_data    <= sample_data_nxt;
      sample_channel <= sample_channel_nxt;
      user_bits      <= user_bits_nxt;
      sample_rdy     <= sample_rdy_nxt;
      frame_rdy      <= frame_rdy_nxt;
      locked         <= locked_nxt;
      error          <= error_nxt;
    end
  end

endmodule

// File: doc/adat_frame_deserializer.md
ADAT_FRAME_DESERIALIZER -- requirements
Module: adat_frame_deserializer

Interface
REQ-001 SHALL have parameter CHANNELS, default 8, number of audio channels per frame (1..8).
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 24, bits per channel sample (multiple of 4, 4..24).
REQ-003 SHALL have parameter SYNC_ZEROS, default 10, zero-run length forming the sync pattern (6..15).
REQ-004 SHALL have parameter LOCK_FRAMES, default 2, consecutive good frames required before lock (1..15).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in  input  1  decoded (NRZI-removed) serial bit, sampled only when enable=1.
REQ-008 enable  input  1  bit strobe; one bit consumed per clk cycle with enable=1.
REQ-009 sample_data  output  SAMPLE_WIDTH  last completed channel sample, MSB first on the wire.
REQ-010 sample_channel  output  clog2(CHANNELS) (min 1)  channel index of sample_data, 0 first.
REQ-011 sample_rdy  output  1  one-cycle pulse: sample_data/sample_channel newly valid.
REQ-012 user_bits  output  4  user bits of the current frame, MSB first on the wire.
REQ-013 frame_rdy  output  1  one-cycle pulse: final sample of a frame delivered.
REQ-014 locked  output  1  level: LOCK_FRAMES consecutive error-free frames received.
REQ-015 error  output  1  one-cycle pulse on any framing violation.

Function
REQ-016 Frame format SHALL be: SYNC_ZEROS zeros, one 1; 4 user bits, separator 1; then CHANNELS*SAMPLE_WIDTH/4 nibbles, each 4 data bits followed by separator 1 (256 bits at defaults).
REQ-017 State machine SHALL have states HUNT, USER, DATA, SYNC; only cycles with enable=1 advance state or counters.
REQ-018 HUNT: count consecutive zeros (saturating at 15); a 1 with count >= SYNC_ZEROS -> USER; a 1 with count < SYNC_ZEROS clears count, stays HUNT, no error.
REQ-019 USER: shift 4 bits into a holding register; 5th bit SHALL be 1 -> DATA and user_bits updated next cycle; 0 -> error, HUNT.
REQ-020 DATA: shift 4 data bits per nibble into a SAMPLE_WIDTH shift register; every 5th bit SHALL be 1, else error, HUNT, partial sample discarded.
REQ-021 After the separator of the last nibble of a channel, sample_data, sample_channel and sample_rdy SHALL update/assert on the following clk cycle (latency 1 cycle from the enable cycle).
REQ-022 Channel counter SHALL increment per completed sample and wrap to 0 after CHANNELS-1; after the last channel, frame_rdy SHALL pulse in the same cycle as that sample_rdy and state -> SYNC.
REQ-023 SYNC: exactly SYNC_ZEROS zeros then 1 -> USER; a 1 after fewer zeros, or a zero after SYNC_ZEROS zeros, -> error, HUNT.
REQ-024 error SHALL pulse one cycle after the offending enable cycle; sample_rdy and frame_rdy SHALL NOT assert for that bit.
REQ-025 Good-frame counter SHALL increment at each frame_rdy (saturating at LOCK_FRAMES); locked SHALL assert in the cycle frame_rdy reaches LOCK_FRAMES, and clear with any error pulse.
REQ-026 sample_rdy/frame_rdy SHALL be produced regardless of locked; consumers qualify with locked.
REQ-027 enable=0 SHALL hold all state, counters and outputs; pulses SHALL still last exactly one clk cycle.
REQ-028 Errors SHALL not be sticky; the block resynchronises from HUNT autonomously.

Reset
REQ-029 reset=1 SHALL, at the next clk edge, force state HUNT, all counters 0, sample_data=0, sample_channel=0, user_bits=0, sample_rdy=0, frame_rdy=0, locked=0, error=0.
REQ-030 reset SHALL take priority over enable, including mid-frame; no pulse SHALL be emitted in the reset cycle or for a frame interrupted by reset.

Verification
REQ-031 Defaults, 3 frames, user=4'b1010, ch k sample=24'h0A0000+k -> 8 sample_rdy per frame with channel 0..7 and matching data; user_bits=4'hA; frame_rdy with ch7; locked high after frame 2.
REQ-032 Locked stream, separator of ch3 nibble 2 forced 0 -> error one cycle later, locked=0, no ch3 sample_rdy; block relocks after next sync plus 2 good frames.
REQ-033 Sync with 9 zeros in SYNC state -> error, HUNT; following valid 10-zero sync accepted; 12-zero run in HUNT accepted as sync.
REQ-034 enable toggled randomly (~30% duty) with REQ-031 stream -> identical sample sequence; each pulse exactly one clk wide.
REQ-035 reset asserted mid-DATA of frame 2 -> all outputs 0 next cycle; no frame_rdy; correct decode from next sync.
REQ-036 CHANNELS=2, SAMPLE_WIDTH=16, SYNC_ZEROS=10 -> 56-bit frames, 2 samples/frame, sample_channel 0,1 wrapping.
